// File: rtl/sne_evt_stream_pkg.sv
// Shared types and constants for the event-driven kernel read path.
package sne_evt_stream_pkg;

  localparam int unsigned MAX_ROWS = 4;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned ROWS_W   = 3;
  localparam int unsigned CH_W     = 6;
  localparam int unsigned ADDR_W   = 8;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic             last;
  } kernel_rd_tag_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } krd_state_t;

  // Zero rows means one row; anything above the configured bound is clamped.
  function automatic logic [ROWS_W-1:0] clamp_rows(input logic [ROWS_W-1:0] rows,
                                                   input int unsigned max_rows);
    if (rows == '0) return ROWS_W'(1);
    if (32'(rows) > max_rows) return ROWS_W'(max_rows);
    return rows;
  endfunction

endpackage

// File: rtl/evt_kernel_rd_buffer.sv
// FIFO holding kernel rows returned by memory, each tagged with its row index and last flag.
module evt_kernel_rd_buffer
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned DW    = 576,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  kernel_rd_tag_t   push_tag,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic             valid,
  output logic [DW-1:0]    data,
  output kernel_rd_tag_t   tag
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    data_q [DEPTH];
  kernel_rd_tag_t   tag_q  [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop & (occ_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) begin
        data_q[wr_q] <= push_data;
        tag_q[wr_q]  <= push_tag;
        wr_q         <= next_ptr(wr_q);
      end
      if (do_pop) rd_q <= next_ptr(rd_q);
      case ({push, do_pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ   = occ_q;
  assign valid = (occ_q != '0);
  assign data  = data_q[rd_q];
  assign tag   = tag_q[rd_q];

  // The sequencer only issues a read when a slot is reserved, so a full push is a bug upstream.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && occ_q == OCC_W'(DEPTH)))
    else $error("evt_kernel_rd_buffer: push into full buffer");

endmodule

// File: rtl/evt_kernel_read_sequencer.sv
// Turns accepted spike events into per-row kernel memory reads and streams the rows out in order.
module evt_kernel_read_sequencer
  import sne_evt_stream_pkg::kernel_rd_tag_t, sne_evt_stream_pkg::krd_state_t,
         sne_evt_stream_pkg::IDLE, sne_evt_stream_pkg::ISSUE, sne_evt_stream_pkg::clamp_rows,
         sne_evt_stream_pkg::CH_W, sne_evt_stream_pkg::ROWS_W, sne_evt_stream_pkg::ROW_W,
         sne_evt_stream_pkg::ADDR_W;
#(
  parameter int unsigned DP_GROUP  = 16,
  parameter int unsigned BUF_DEPTH = 3,
  parameter int unsigned MAX_ROWS  = sne_evt_stream_pkg::MAX_ROWS
) (
  input  logic                  engine_clk_i,
  input  logic                  engine_rst_ni,
  input  logic                  flush_i,
  input  logic [ROWS_W-1:0]     rows_i,
  input  logic                  evt_valid_i,
  output logic                  evt_ready_o,
  input  logic [CH_W-1:0]       evt_ch_i,
  output logic                  mem_enable_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic [36*DP_GROUP-1:0] mem_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [36*DP_GROUP-1:0] out_data_o,
  output logic [ROW_W-1:0]      out_row_o,
  output logic                  out_last_o
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

  krd_state_t        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ROWS_W-1:0] rows_q, rows_d;
  logic [ROW_W-1:0]  r_q, r_d;
  kernel_rd_tag_t    tag_q, tag_d;
  kernel_rd_tag_t    head_tag;
  logic              inflight_q;
  logic [OCC_W-1:0]  occ;
  logic              accept, issue, issue_ok, last_row, pop;

  assign evt_ready_o = (state_q == IDLE) & ~flush_i;
  assign accept      = evt_valid_i & evt_ready_o;
  // Registered counts only: a slot freed by this cycle's pop is not reused until next cycle.
  assign issue_ok    = (32'(occ) + 32'(inflight_q)) < BUF_DEPTH;
  assign last_row    = (ROWS_W'(r_q) + ROWS_W'(1)) >= rows_q;
  assign mem_addr_o  = ADDR_W'(ch_q) * ADDR_W'(rows_q) + ADDR_W'(r_q);
  assign mem_enable_o = issue;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rows_d  = rows_q;
    r_d     = r_q;
    tag_d   = tag_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ch_d    = evt_ch_i;
          rows_d  = clamp_rows(rows_i, MAX_ROWS);
          r_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_ok) begin
          issue      = 1'b1;
          tag_d.row  = r_q;
          tag_d.last = last_row;
          if (last_row) begin
            r_d     = '0;
            state_d = IDLE;
          end else begin
            r_d = r_q + ROW_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over any accept or issue in the same cycle.
    if (flush_i) begin
      state_d = IDLE;
      r_d     = '0;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
    if (!engine_rst_ni) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      rows_q     <= '0;
      r_q        <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rows_q     <= rows_d;
      r_q        <= r_d;
      tag_q      <= tag_d;
      inflight_q <= issue;
    end
  end

  assign pop = out_valid_o & out_ready_i;

  evt_kernel_rd_buffer #(
    .DEPTH (BUF_DEPTH),
    .DW    (36 * DP_GROUP)
  ) u_buf (
    .clk       (engine_clk_i),
    .rst_n     (engine_rst_ni),
    .flush     (flush_i),
    .push      (inflight_q),
    .push_data (mem_data_i),
    .push_tag  (tag_q),
    .pop       (pop),
    .occ       (occ),
    .valid     (out_valid_o),
    .data      (out_data_o),
    .tag       (head_tag)
  );

  assign out_row_o  = head_tag.row;
  assign out_last_o = head_tag.last;

endmodule

// File: tb/tb_evt_kernel_read_sequencer.sv
// Directed bench for evt_kernel_read_sequencer: memory model, read/output logs, per-scenario checks.
module tb_evt_kernel_read_sequencer;

  localparam int unsigned DP_GROUP  = 16;
  localparam int unsigned BUF_DEPTH = 3;
  localparam int unsigned DW        = 36 * DP_GROUP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          evt_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    rows = '0;
  logic [5:0]    ch = '0;
  logic          evt_ready, mem_enable, out_valid, out_last;
  logic [7:0]    mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_row;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  int            rd_cyc[$];
  logic [7:0]    rd_addr[$];
  int            o_cyc[$];
  logic [1:0]    o_row[$];
  logic          o_last[$];
  logic [DW-1:0] o_data[$];

  evt_kernel_read_sequencer #(
    .DP_GROUP (DP_GROUP),
    .BUF_DEPTH(BUF_DEPTH),
    .MAX_ROWS (4)
  ) dut (
    .engine_clk_i (clk),
    .engine_rst_ni(rst_n),
    .flush_i      (flush),
    .rows_i       (rows),
    .evt_valid_i  (evt_valid),
    .evt_ready_o  (evt_ready),
    .evt_ch_i     (ch),
    .mem_enable_o (mem_enable),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_row_o    (out_row),
    .out_last_o   (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    return {{(DW/8-1){a}}, a ^ 8'h5A};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_enable) mem_data <= pat(mem_addr);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_enable) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(mem_addr);
      end
      if (out_valid && out_ready) begin
        o_cyc.push_back(cyc);
        o_row.push_back(out_row);
        o_last.push_back(out_last);
        o_data.push_back(out_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete();
    o_cyc.delete(); o_row.delete(); o_last.delete(); o_data.delete();
  endtask

  // Starts and ends just after a rising edge; acc is the cycle the event was accepted in.
  task automatic send_event(input logic [5:0] c, input logic [2:0] r, output int acc);
    acc = -1;
    evt_valid = 1'b1; ch = c; rows = r;
    for (int k = 0; k < 200 && acc < 0; k++) begin
      @(negedge clk);
      if (evt_ready) acc = cyc;
      tick();
    end
    evt_valid = 1'b0;
    tests++;
    if (acc < 0) begin fails++; $display("FAIL accept_timeout ch=%0d: event never accepted", c); end
  endtask

  task automatic test_reset();
    tests++;
    if ({evt_ready, mem_enable, mem_addr, out_valid, out_row, out_last} !== {1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy=%b en=%b addr=%0d ov=%b row=%0d last=%b want 1 0 0 0 0 0",
               evt_ready, mem_enable, mem_addr, out_valid, out_row, out_last);
    end
    tests++;
    if (out_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", out_data[31:0]); end
  endtask

  task automatic test_basic();
    int acc;
    clear_logs(); out_ready = 1'b1;
    send_event(6'd5, 3'd3, acc);
    repeat (8) tick();
    tests++;
    if (rd_addr.size() != 3) begin fails++; $display("FAIL basic_reads: got %0d want 3", rd_addr.size()); end
    for (int i = 0; i < rd_addr.size() && i < 3; i++) begin
      tests++;
      if (rd_addr[i] !== 8'(15 + i) || rd_cyc[i] !== acc + 1 + i) begin
        fails++;
        $display("FAIL basic_rd%0d: got addr=%0d cyc=%0d want addr=%0d cyc=%0d", i, rd_addr[i], rd_cyc[i], 15 + i, acc + 1 + i);
      end
    end
    tests++;
    if (o_row.size() != 3) begin fails++; $display("FAIL basic_outs: got %0d want 3", o_row.size()); end
    for (int i = 0; i < o_row.size() && i < 3; i++) begin
      tests++;
      if (o_row[i] !== 2'(i) || o_last[i] !== (i == 2) || o_data[i] !== pat(8'(15 + i))) begin
        fails++;
        $display("FAIL basic_out%0d: got row=%0d last=%b want row=%0d last=%b (or data)", i, o_row[i], o_last[i], i, i == 2);
      end
    end
    tests++;
    if (o_cyc.size() == 0 || o_cyc[0] !== acc + 3) begin
      fails++; $display("FAIL basic_latency: first output not at cycle %0d (accept %0d)", acc + 3, acc);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    clear_logs(); out_ready = 1'b0;
    send_event(6'd2, 3'd4, acc);
    repeat (8) tick();
    tests++;
    if (rd_addr.size() != BUF_DEPTH) begin fails++; $display("FAIL bp_reads_stalled: got %0d want %0d", rd_addr.size(), BUF_DEPTH); end
    tests++;
    if (mem_enable !== 1'b0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_hold: got en=%b ov=%b want en=0 ov=1", mem_enable, out_valid);
    end
    out_ready = 1'b1;
    repeat (10) tick();
    tests++;
    if (rd_addr.size() != 4 || o_row.size() != 4) begin
      fails++; $display("FAIL bp_drain_count: got reads=%0d outs=%0d want 4 4", rd_addr.size(), o_row.size());
    end
    for (int i = 0; i < o_row.size() && i < 4; i++) begin
      tests++;
      if (o_row[i] !== 2'(i) || o_last[i] !== (i == 3) || o_data[i] !== pat(8'(8 + i))) begin
        fails++; $display("FAIL bp_out%0d: got row=%0d last=%b want row=%0d last=%b (or data)", i, o_row[i], o_last[i], i, i == 3);
      end
    end
  endtask

  task automatic test_rows_range();
    int acc;
    int ea[9] = '{252, 253, 254, 255, 7, 40, 41, 42, 43};
    int er[9] = '{0, 1, 2, 3, 0, 0, 1, 2, 3};
    int el[9] = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
    clear_logs(); out_ready = 1'b1;
    send_event(6'd63, 3'd4, acc);
    send_event(6'd7, 3'd0, acc);
    send_event(6'd10, 3'd7, acc);
    repeat (10) tick();
    tests++;
    if (rd_addr.size() != 9 || o_row.size() != 9) begin
      fails++; $display("FAIL range_count: got reads=%0d outs=%0d want 9 9", rd_addr.size(), o_row.size());
    end
    for (int i = 0; i < 9 && i < rd_addr.size() && i < o_row.size(); i++) begin
      tests++;
      if (rd_addr[i] !== 8'(ea[i]) || o_row[i] !== 2'(er[i]) || o_last[i] !== 1'(el[i]) || o_data[i] !== pat(8'(ea[i]))) begin
        fails++;
        $display("FAIL range_%0d: got addr=%0d row=%0d last=%b want addr=%0d row=%0d last=%0d", i, rd_addr[i], o_row[i], o_last[i], ea[i], er[i], el[i]);
      end
    end
  endtask

  task automatic test_flush();
    int acc;
    clear_logs(); out_ready = 1'b1;
    send_event(6'd3, 3'd4, acc);
    tick();
    tick();
    flush = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_enable !== 1'b0 || evt_ready !== 1'b0) begin
      fails++; $display("FAIL flush_override: got en=%b rdy=%b want 0 0", mem_enable, evt_ready);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    tick();
    repeat (6) tick();
    tests++;
    if (rd_addr.size() != 2 || o_row.size() != 1) begin
      fails++; $display("FAIL flush_counts: got reads=%0d outs=%0d want 2 1", rd_addr.size(), o_row.size());
    end
    tests++;
    if (o_cyc.size() == 0 || o_cyc[0] !== acc + 3 || o_data[0] !== pat(8'd12)) begin
      fails++; $display("FAIL flush_first_row: row 0 not delivered at cycle %0d", acc + 3);
    end
    clear_logs();
    send_event(6'd1, 3'd1, acc);
    repeat (6) tick();
    tests++;
    if (rd_addr.size() != 1 || (rd_addr.size() > 0 && rd_addr[0] !== 8'd1)) begin
      fails++; $display("FAIL flush_next_read: got %0d reads want 1 read at addr 1", rd_addr.size());
    end
    tests++;
    if (o_row.size() != 1 || (o_row.size() > 0 && (o_row[0] !== 2'd0 || o_last[0] !== 1'b1 || o_data[0] !== pat(8'd1)))) begin
      fails++; $display("FAIL flush_next_out: got %0d outputs want single row 0 last", o_row.size());
    end
  endtask

  task automatic test_async_reset();
    int acc;
    clear_logs(); out_ready = 1'b0;
    send_event(6'd4, 3'd3, acc);
    tick();
    tick();
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== pat(8'd12)) begin
      fails++; $display("FAIL arst_pre: got ov=%b want 1 with row 0 data", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_enable, mem_addr, out_valid, out_row, out_last, evt_ready} !== {1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1} || out_data !== '0) begin
      fails++; $display("FAIL arst_now: got en=%b addr=%0d ov=%b row=%0d last=%b want all reset", mem_enable, mem_addr, out_valid, out_row, out_last);
    end
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
    out_ready = 1'b1;
    repeat (8) tick();
    tests++;
    if (rd_addr.size() != 0 || o_row.size() != 0) begin
      fails++; $display("FAIL arst_stale: got reads=%0d outs=%0d want 0 0", rd_addr.size(), o_row.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc, n, c, r;
    int eaddr[$];
    int erow[$];
    int elast[$];
    clear_logs(); rand_rdy = 1'b1;
    for (int e = 0; e < 10; e++) begin
      c = $urandom_range(0, 63);
      r = $urandom_range(0, 7);
      n = (r == 0) ? 1 : ((r > 4) ? 4 : r);
      send_event(6'(c), 3'(r), acc);
      for (int j = 0; j < n; j++) begin
        eaddr.push_back((c * n + j) % 256);
        erow.push_back(j);
        elast.push_back(j == n - 1);
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    tests++;
    if (o_row.size() != eaddr.size() || rd_addr.size() != eaddr.size()) begin
      fails++; $display("FAIL b2b_count: got reads=%0d outs=%0d want %0d", rd_addr.size(), o_row.size(), eaddr.size());
    end
    for (int i = 0; i < eaddr.size() && i < o_row.size() && i < rd_addr.size(); i++) begin
      tests++;
      if (rd_addr[i] !== 8'(eaddr[i]) || o_row[i] !== 2'(erow[i]) || o_last[i] !== 1'(elast[i]) || o_data[i] !== pat(8'(eaddr[i]))) begin
        fails++;
        $display("FAIL b2b_%0d: got addr=%0d row=%0d last=%b want addr=%0d row=%0d last=%0d", i, rd_addr[i], o_row[i], o_last[i], eaddr[i], erow[i], elast[i]);
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_rows_range();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
